// File: rtl/rr_regfile_history_buf.sv
// rr_regfile_history_buf
//   Register-file write history buffer for rapid recovery. Every cycle in
//   which any write port fires, the whole write bundle (all ports, including
//   disabled ones) is appended to a circular buffer. Commits from the checker
//   retire the oldest bundle. On rollback the uncommitted bundles are replayed
//   oldest-first over a valid/ready stream so the register file can be restored.
//
// Ports
//   clk_i, rst_i (async, active-high), clear_i (sync flush, top priority)
//   wr_we_i/wr_addr_i/wr_data_i : per-port write bundle, port k at [k*W +: W]
//   commit_i                    : retire oldest bundle (IDLE only)
//   replay_start_i              : begin rollback replay (IDLE only)
//   replay_valid_o/replay_ready_i, replay_we_o/addr_o/data_o : replay stream
//   replay_done_o               : single-cycle pulse at end of replay
//   busy_o, full_o, empty_o, count_o, overflow_o (sticky dropped push)
module rr_regfile_history_buf #(
  parameter int NumWrPorts = 2,
  parameter int Depth      = 8,
  parameter int AddrWidth  = 5,
  parameter int DataWidth  = 32,
  parameter int CntWidth   = $clog2(Depth + 1)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            clear_i,
  input  logic [NumWrPorts-1:0]           wr_we_i,
  input  logic [NumWrPorts*AddrWidth-1:0] wr_addr_i,
  input  logic [NumWrPorts*DataWidth-1:0] wr_data_i,
  input  logic                            commit_i,
  input  logic                            replay_start_i,
  output logic                            replay_valid_o,
  input  logic                            replay_ready_i,
  output logic [NumWrPorts-1:0]           replay_we_o,
  output logic [NumWrPorts*AddrWidth-1:0] replay_addr_o,
  output logic [NumWrPorts*DataWidth-1:0] replay_data_o,
  output logic                            replay_done_o,
  output logic                            busy_o,
  output logic                            full_o,
  output logic                            empty_o,
  output logic [CntWidth-1:0]             count_o,
  output logic                            overflow_o
);

  localparam int PtrW = $clog2(Depth);

  typedef enum logic [1:0] {IDLE, REPLAY, DONE} state_e;

  state_e                state_q, state_d;
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntWidth-1:0]   count_q;
  logic                  overflow_q;

  // Bundle storage; deliberately not reset.
  logic [NumWrPorts-1:0]           we_mem   [Depth];
  logic [NumWrPorts*AddrWidth-1:0] addr_mem [Depth];
  logic [NumWrPorts*DataWidth-1:0] data_mem [Depth];

  logic is_full, is_empty;
  logic push_req, commit_ok, push_ok;
  logic idle_op, store_en, retire_en, drop_en, handshake;

  assign is_full  = (count_q == CntWidth'(Depth));
  assign is_empty = (count_q == '0);

  assign push_req  = |wr_we_i;
  assign commit_ok = commit_i && !is_empty;
  // A commit in the same cycle frees the slot a full buffer would need.
  assign push_ok   = push_req && (!is_full || commit_ok);

  // Pushes and commits only take effect in IDLE, and a start request or a
  // flush in the same cycle suppresses them.
  assign idle_op   = (state_q == IDLE) && !clear_i && !replay_start_i;
  assign store_en  = idle_op && push_ok;
  assign retire_en = idle_op && commit_ok;
  assign drop_en   = idle_op && push_req && !push_ok;
  assign handshake = (state_q == REPLAY) && replay_ready_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (replay_start_i) state_d = is_empty ? DONE : REPLAY;
      REPLAY:  if (handshake && (count_q == CntWidth'(1))) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear_i) state_d = IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (clear_i) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (store_en) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (retire_en || handshake) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      // handshake only occurs in REPLAY, where store_en is never set.
      if (store_en && !retire_en)
        count_q <= count_q + CntWidth'(1);
      else if (!store_en && (retire_en || handshake))
        count_q <= count_q - CntWidth'(1);
      if (drop_en) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (store_en) begin
      we_mem[wr_ptr_q]   <= wr_we_i;
      addr_mem[wr_ptr_q] <= wr_addr_i;
      data_mem[wr_ptr_q] <= wr_data_i;
    end
  end

  // Replay payload is gated by valid so the outputs read zero outside REPLAY,
  // including immediately on an asynchronous reset.
  assign replay_valid_o = (state_q == REPLAY);
  assign replay_we_o    = replay_valid_o ? we_mem[rd_ptr_q]   : '0;
  assign replay_addr_o  = replay_valid_o ? addr_mem[rd_ptr_q] : '0;
  assign replay_data_o  = replay_valid_o ? data_mem[rd_ptr_q] : '0;
  assign replay_done_o  = (state_q == DONE);
  assign busy_o         = (state_q != IDLE);
  assign full_o         = is_full;
  assign empty_o        = is_empty;
  assign count_o        = count_q;
  assign overflow_o     = overflow_q;

endmodule

// File: tb/tb_rr_regfile_history_buf.sv
// Directed bench for rr_regfile_history_buf (Depth=8, NumWrPorts=2).
module tb_rr_regfile_history_buf;

  localparam int NP = 2;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int CW = 4;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic            clear_i = 1'b0;
  logic [NP-1:0]   wr_we_i = '0;
  logic [NP*AW-1:0] wr_addr_i = '0;
  logic [NP*DW-1:0] wr_data_i = '0;
  logic            commit_i = 1'b0;
  logic            replay_start_i = 1'b0;
  logic            replay_valid_o;
  logic            replay_ready_i = 1'b1;
  logic [NP-1:0]   replay_we_o;
  logic [NP*AW-1:0] replay_addr_o;
  logic [NP*DW-1:0] replay_data_o;
  logic            replay_done_o;
  logic            busy_o;
  logic            full_o;
  logic            empty_o;
  logic [CW-1:0]   count_o;
  logic            overflow_o;

  int n_cmp = 0;
  int n_err = 0;

  rr_regfile_history_buf #(
    .NumWrPorts(NP), .Depth(8), .AddrWidth(AW), .DataWidth(DW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i),
    .wr_we_i(wr_we_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .commit_i(commit_i), .replay_start_i(replay_start_i),
    .replay_valid_o(replay_valid_o), .replay_ready_i(replay_ready_i),
    .replay_we_o(replay_we_o), .replay_addr_o(replay_addr_o),
    .replay_data_o(replay_data_o), .replay_done_o(replay_done_o),
    .busy_o(busy_o), .full_o(full_o), .empty_o(empty_o),
    .count_o(count_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  // Test bundle i: bundle 0 is {we=01, a0=5, d0=0xAA}.
  function automatic logic [NP-1:0] bwe(input int i);
    case (i % 3)
      0:       return 2'b01;
      1:       return 2'b10;
      default: return 2'b11;
    endcase
  endfunction
  function automatic logic [NP*AW-1:0] baddr(input int i);
    return {5'((i + 10) % 32), 5'((i + 5) % 32)};
  endfunction
  function automatic logic [NP*DW-1:0] bdata(input int i);
    return {32'(32'h100 + i), 32'(32'hAA + i)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_bundle(input int i);
    wr_we_i   = bwe(i);
    wr_addr_i = baddr(i);
    wr_data_i = bdata(i);
  endtask

  task automatic idle_inputs();
    wr_we_i = '0; wr_addr_i = '0; wr_data_i = '0; commit_i = 1'b0;
  endtask

  task automatic push(input int i);
    drive_bundle(i);
    step();
    idle_inputs();
  endtask

  task automatic chk_bundle(input string tag, input int i);
    chk({tag, "_valid"}, 64'(replay_valid_o), 64'(1));
    chk({tag, "_we"},    64'(replay_we_o),    64'(bwe(i)));
    chk({tag, "_addr"},  64'(replay_addr_o),  64'(baddr(i)));
    chk({tag, "_data"},  64'(replay_data_o),  64'(bdata(i)));
  endtask

  task automatic start_replay();
    replay_start_i = 1'b1;
    step();
    replay_start_i = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_empty", 64'(empty_o), 64'(1));
    chk("rst_count", 64'(count_o), 64'(0));
    chk("rst_full", 64'(full_o), 64'(0));
    chk("rst_ovf", 64'(overflow_o), 64'(0));
    chk("rst_busy", 64'(busy_o), 64'(0));
    chk("rst_valid", 64'(replay_valid_o), 64'(0));
    chk("rst_done", 64'(replay_done_o), 64'(0));
    #5 rst_i = 1'b0;
    step();

    // Ordered replay of three bundles
    push(0); push(1); push(2);
    chk("t1_count3", 64'(count_o), 64'(3));
    start_replay();
    chk("t1_first_we", 64'(replay_we_o), 64'(2'b01));
    chk("t1_first_a0", 64'(replay_addr_o[AW-1:0]), 64'(5));
    chk("t1_first_d0", 64'(replay_data_o[DW-1:0]), 64'(32'hAA));
    for (int j = 0; j < 3; j++) begin
      chk_bundle("t1_rep", j);
      step();
    end
    chk("t1_valid_off", 64'(replay_valid_o), 64'(0));
    chk("t1_done", 64'(replay_done_o), 64'(1));
    chk("t1_count0", 64'(count_o), 64'(0));
    chk("t1_empty", 64'(empty_o), 64'(1));
    step();
    chk("t1_done_once", 64'(replay_done_o), 64'(0));
    chk("t1_idle", 64'(busy_o), 64'(0));

    // Full, overflow, wrap (write pointer starts at 3)
    for (int j = 3; j <= 10; j++) push(j);
    chk("t2_full", 64'(full_o), 64'(1));
    chk("t2_count8", 64'(count_o), 64'(8));
    push(99);
    chk("t2_ovf", 64'(overflow_o), 64'(1));
    chk("t2_count_ovf", 64'(count_o), 64'(8));
    commit_i = 1'b1; step(); step(); commit_i = 1'b0;
    chk("t2_count6", 64'(count_o), 64'(6));
    push(11); push(12);
    chk("t2_refull", 64'(count_o), 64'(8));
    start_replay();
    for (int j = 5; j <= 12; j++) begin
      chk_bundle("t2_rep", j);
      step();
    end
    chk("t2_done", 64'(replay_done_o), 64'(1));
    chk("t2_ovf_sticky", 64'(overflow_o), 64'(1));
    step();
    clear_i = 1'b1; step(); clear_i = 1'b0;
    chk("t2_ovf_clr", 64'(overflow_o), 64'(0));

    // Full with simultaneous commit and push
    for (int j = 20; j <= 27; j++) push(j);
    chk("t3_full", 64'(full_o), 64'(1));
    commit_i = 1'b1;
    push(28);
    chk("t3_count8", 64'(count_o), 64'(8));
    chk("t3_ovf0", 64'(overflow_o), 64'(0));
    start_replay();
    for (int j = 21; j <= 28; j++) begin
      chk_bundle("t3_rep", j);
      step();
    end
    chk("t3_done", 64'(replay_done_o), 64'(1));
    step();

    // Backpressure, with pushes/commits presented during the replay
    push(30); push(31);
    replay_ready_i = 1'b0;
    start_replay();
    drive_bundle(40);
    commit_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk_bundle("t4_stall", 30);
      chk("t4_stall_cnt", 64'(count_o), 64'(2));
      step();
    end
    replay_ready_i = 1'b1;
    chk_bundle("t4_rep", 30);
    step();
    chk_bundle("t4_rep", 31);
    step();
    idle_inputs();
    chk("t4_done", 64'(replay_done_o), 64'(1));
    chk("t4_count0", 64'(count_o), 64'(0));
    step();
    chk("t4_count_after", 64'(count_o), 64'(0));

    // Replay of empty buffer
    start_replay();
    chk("t5_valid", 64'(replay_valid_o), 64'(0));
    chk("t5_done", 64'(replay_done_o), 64'(1));
    chk("t5_busy", 64'(busy_o), 64'(1));
    step();
    chk("t5_done_off", 64'(replay_done_o), 64'(0));
    chk("t5_busy_off", 64'(busy_o), 64'(0));

    // Clear mid-replay
    for (int j = 50; j <= 54; j++) push(j);
    start_replay();
    chk_bundle("t6_rep", 50); step();
    chk_bundle("t6_rep", 51); step();
    chk("t6_count3", 64'(count_o), 64'(3));
    clear_i = 1'b1; step(); clear_i = 1'b0;
    chk("t6_valid", 64'(replay_valid_o), 64'(0));
    chk("t6_count", 64'(count_o), 64'(0));
    chk("t6_ovf", 64'(overflow_o), 64'(0));
    chk("t6_busy", 64'(busy_o), 64'(0));
    chk("t6_done", 64'(replay_done_o), 64'(0));
    step();
    chk("t6_done_later", 64'(replay_done_o), 64'(0));

    // Asynchronous reset mid-replay
    push(60); push(61); push(62);
    start_replay();
    chk_bundle("t7_rep", 60); step();
    chk("t7_mid_busy", 64'(busy_o), 64'(1));
    #2 rst_i = 1'b1;
    #1;
    chk("t7_valid", 64'(replay_valid_o), 64'(0));
    chk("t7_we", 64'(replay_we_o), 64'(0));
    chk("t7_data", 64'(replay_data_o), 64'(0));
    chk("t7_busy", 64'(busy_o), 64'(0));
    chk("t7_count", 64'(count_o), 64'(0));
    chk("t7_empty", 64'(empty_o), 64'(1));
    chk("t7_done", 64'(replay_done_o), 64'(0));
    rst_i = 1'b0;
    step();
    chk("t7_done_after", 64'(replay_done_o), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
